mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Initiator side of the CPU data-memory interface: accepts one load/store request from the pipeline over a valid/ready handshake.
- Drives the memory port (en/rw/addr/len/dataIn) for a fixed number of cycles, then captures dataOut.
- Returns a size-adjusted, sign/zero-extended result over a second valid/ready handshake.
- Sits between the EXU/WBU stage and the memory responder; one outstanding request at a time.

Parameters:
- MEM_LATENCY, 1, cycles mem_en is held per access; legal range 1..15; read data is sampled on the last cycle.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_size  input  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  input  64  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts the response
- resp_rdata  output  64  load result; 0 for stores and errors
- resp_err  output  1  misaligned request
- mem_en  output  1  memory access enable
- mem_rw  output  1  1 = write, 0 = read
- mem_addr  output  64  byte address to memory
- mem_len  output  4  byte count: 1, 2, 4 or 8
- mem_dataIn  output  64  write data, right-aligned, upper bytes zero
- mem_dataOut  input  64  read data, bytes from mem_addr right-aligned

Behaviour:
- Reset values of all outputs: state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; mem_en = 0; mem_rw = 0; mem_addr = 0; mem_len = 0; mem_dataIn = 0.
- FSM states:
  - IDLE: req_ready = 1. On req_valid, latch all request fields.
    - If addr mod len != 0, go to RESP with err = 1.
    - Otherwise go to ACCESS with cnt = MEM_LATENCY-1.
  - ACCESS: mem_en = 1. mem_rw, mem_addr, mem_len and mem_dataIn are driven from the latched registers and held stable.
    - cnt decrements each cycle.
    - When cnt == 0: capture the data, drop mem_en on the next cycle, and go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are stable. When resp_ready = 1, go to IDLE.
- Outside ACCESS: mem_en = 0 and mem_rw = 0. mem_addr, mem_len and mem_dataIn keep their last values.
- req_ready = 1 only in IDLE. Minimum request-to-response latency is MEM_LATENCY+1 cycles; no back-to-back overlap.
- Load extension: take the low 8*len bits of mem_dataOut. Replicate bit 8*len-1 (signed) or 0 (unsigned) into the upper bits. For size 3 the full 64 bits pass through.
- Stores: mem_dataIn = req_wdata masked to len bytes; resp_rdata = 0.
- Errors: a misaligned request never asserts mem_en. resp_err = 1 and resp_rdata = 0.
- Backpressure: while resp_ready = 0 the block stays in RESP indefinitely and the outputs are unchanged.
- Reset asserted mid-ACCESS or mid-RESP: immediate return to reset values. mem_en drops asynchronously and any in-flight response is discarded.
- Reset release while req_valid = 1: the request is accepted on the first clock edge after release.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined: adds output ports stat_loads[31:0], stat_stores[31:0] and stat_misaligned[31:0].
  - Each counter increments by 1 on request acceptance in IDLE, according to type and alignment.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load word, signed: req_addr = 0x80000004, size = 2, unsigned = 0, mem_dataOut = 0xDEADBEEF_80001234, MEM_LATENCY = 1 -> mem_en high for 1 cycle with mem_len = 4; resp_rdata = 0xFFFFFFFF_80001234, resp_err = 0.
- Load byte, unsigned: addr = 0x80000003, size = 0, mem_dataOut = 0x...00F0 -> resp_rdata = 0x00000000_000000F0.
- Store half: addr = 0x80000010, size = 1, wdata = 0x1122334455667788 -> mem_rw = 1, mem_len = 2, mem_dataIn = 0x0000000000007788; resp_rdata = 0.
- Misaligned: addr = 0x80000002, size = 2 -> mem_en never asserted; resp_err = 1 one cycle after acceptance.
- MEM_LATENCY = 3 with resp_ready held 0 for 5 cycles -> mem_en high exactly 3 cycles; resp_valid and resp_rdata stable for 5 cycles; req_ready = 0 throughout.
- Reset asserted on the 2nd ACCESS cycle -> mem_en = 0 and req_ready = 1 with no clock edge; no resp_valid afterwards; with LSU_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, driven onto a fixed-latency memory port.
// Define LSU_STATS_EN to add load/store/misaligned request counters.
module mem_lsu #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [63:0] mem_addr,
    output logic [3:0]  mem_len,
    output logic [63:0] mem_dataIn,
    input  logic [63:0] mem_dataOut
`ifdef LSU_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wen_q;
    logic        unsigned_q;
    logic [1:0]  size_q;

    logic        misalign_d;
    logic [3:0]  len_d;
    logic [63:0] wdata_d;
    logic [63:0] ext_d;

    always_comb begin
        len_d = 4'b0001 << req_size;
        unique case (req_size)
            2'd0: begin misalign_d = 1'b0;                 wdata_d = {56'b0, req_wdata[7:0]};  end
            2'd1: begin misalign_d = req_addr[0];          wdata_d = {48'b0, req_wdata[15:0]}; end
            2'd2: begin misalign_d = |req_addr[1:0];       wdata_d = {32'b0, req_wdata[31:0]}; end
            default: begin misalign_d = |req_addr[2:0];    wdata_d = req_wdata;                end
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'd0: ext_d = {{56{mem_dataOut[7]  & ~unsigned_q}}, mem_dataOut[7:0]};
            2'd1: ext_d = {{48{mem_dataOut[15] & ~unsigned_q}}, mem_dataOut[15:0]};
            2'd2: ext_d = {{32{mem_dataOut[31] & ~unsigned_q}}, mem_dataOut[31:0]};
            default: ext_d = mem_dataOut;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_len    <= '0;
            mem_dataIn <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wen_q      <= req_wen;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        req_ready  <= 1'b0;
                        if (misalign_d) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state_q    <= ACCESS;
                            cnt_q      <= 4'(MEM_LATENCY - 1);
                            mem_en     <= 1'b1;
                            mem_rw     <= req_wen;
                            mem_addr   <= req_addr;
                            mem_len    <= len_d;
                            mem_dataIn <= wdata_d;
                        end
                    end
                end
                ACCESS: begin
                    // Read data is sampled on the edge that closes the last enable cycle.
                    if (cnt_q == '0) begin
                        state_q    <= RESP;
                        mem_en     <= 1'b0;
                        mem_rw     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wen_q ? '0 : ext_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q    <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_loads      <= '0;
            stat_stores     <= '0;
            stat_misaligned <= '0;
        end else if (state_q == IDLE && req_valid) begin
            if (misalign_d)   stat_misaligned <= stat_misaligned + 32'd1;
            else if (req_wen) stat_stores     <= stat_stores + 32'd1;
            else              stat_loads      <= stat_loads + 32'd1;
        end
    end
`endif

endmodule
